vie_wb_stage: RTL and testbench

Write-back stage of the five-stage vie pipeline. Latches the 72-bit memory-stage bus, commits results to the general register file or the HI/LO registers, and drives the debug trace port. It also exports a status bus for forwarding and serves the decode stage's two register read ports through an internal register file with write-through bypass.

---
 rtl/vie_wb_stage_pkg.sv | 36 +++
 rtl/vie_wb_stage_regfile.sv | 44 ++++
 rtl/vie_wb_stage.sv | 84 ++++++++
 tb/tb_vie_wb_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vie_wb_stage_pkg.sv
// Shared widths, bus layouts and destination decoding for the vie write-back stage.
package vie_wb_stage_pkg;

    localparam int VMSBUS   = 72;
    localparam int VWSTATUS = 40;

    localparam logic [6:0] VIE_DEST_HI = 7'd32;
    localparam logic [6:0] VIE_DEST_LO = 7'd33;

    typedef struct packed {
        logic        valid;
        logic [6:0]  dest;
        logic [31:0] pc;
        logic [31:0] result;
    } msbus_t;

    typedef enum logic [1:0] {
        DK_NONE = 2'd0,
        DK_GPR  = 2'd1,
        DK_HI   = 2'd2,
        DK_LO   = 2'd3
    } dest_kind_e;

    // dest 0 and 34..127 retire without any architectural write
    function automatic dest_kind_e decode_dest(input logic [6:0] dest);
        if (dest == VIE_DEST_HI)
            return DK_HI;
        else if (dest == VIE_DEST_LO)
            return DK_LO;
        else if (dest >= 7'd1 && dest <= 7'd31)
            return DK_GPR;
        else
            return DK_NONE;
    endfunction

endpackage

// File: rtl/vie_wb_stage_regfile.sv
// 32x32 general register file: one write port, two combinational read ports
// with write-through bypass, r0 hardwired to zero.
module vie_regfile (
    input  logic        clock,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);

    logic [31:0] mem [0:31];
    logic [4:0]  raddr [0:1];
    logic [31:0] rdata [0:1];

    // r1..r31 are deliberately not reset; software writes before reading
    always_ff @(posedge clock) begin
        if (we && waddr != 5'd0)
            mem[waddr] <= wdata;
    end

    assign raddr[0] = raddr1;
    assign raddr[1] = raddr2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            always_comb begin
                if (raddr[gi] == 5'd0)
                    rdata[gi] = 32'd0;
                else if (we && raddr[gi] == waddr)
                    rdata[gi] = wdata;
                else
                    rdata[gi] = mem[raddr[gi]];
            end
        end
    endgenerate

    assign rdata1 = rdata[0];
    assign rdata2 = rdata[1];

endmodule

// File: rtl/vie_wb_stage.sv
// Write-back stage: latches the memory-stage bus, commits to GPR/HI/LO,
// exports forwarding status and the debug trace port.
module vie_wb_stage
    import vie_wb_stage_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [VMSBUS-1:0]   msbus_i,
    output logic                ws_allowin,
    input  logic [4:0]          rf_raddr1,
    output logic [31:0]         rf_rdata1,
    input  logic [4:0]          rf_raddr2,
    output logic [31:0]         rf_rdata2,
    output logic [31:0]         hi_o,
    output logic [31:0]         lo_o,
    output logic [VWSTATUS-1:0] wstatus_o,
    output logic [31:0]         debug_wb_pc,
    output logic [3:0]          debug_wb_rf_wen,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [31:0]         debug_wb_rf_wdata
);

    msbus_t      ws_r;
    logic        ws_valid_r;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        ws_cango;
    logic        rf_we;
    dest_kind_e  dest_kind;

    assign ws_cango   = 1'b1;
    assign ws_allowin = !ws_valid_r || ws_cango;

    always_ff @(posedge clock) begin
        if (reset)
            ws_valid_r <= 1'b0;
        else if (ws_allowin)
            ws_valid_r <= msbus_i[71];
    end

    // Payload only moves on a valid transfer; bubbles leave the old contents in place
    always_ff @(posedge clock) begin
        if (msbus_i[71] && ws_allowin)
            ws_r <= msbus_t'(msbus_i);
    end

    assign dest_kind = decode_dest(ws_r.dest);

    // Gating with reset keeps the instruction caught in WB from writing at the reset edge
    assign rf_we = ws_valid_r && (dest_kind == DK_GPR) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else if (ws_valid_r) begin
            if (dest_kind == DK_HI)
                hi_reg <= ws_r.result;
            if (dest_kind == DK_LO)
                lo_reg <= ws_r.result;
        end
    end

    vie_regfile u_regfile (
        .clock  (clock),
        .we     (rf_we),
        .waddr  (ws_r.dest[4:0]),
        .wdata  (ws_r.result),
        .raddr1 (rf_raddr1),
        .rdata1 (rf_rdata1),
        .raddr2 (rf_raddr2),
        .rdata2 (rf_rdata2)
    );

    assign hi_o      = hi_reg;
    assign lo_o      = lo_reg;
    assign wstatus_o = {ws_valid_r, ws_r.dest, ws_r.result};

    assign debug_wb_pc       = ws_r.pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_r.dest[4:0];
    assign debug_wb_rf_wdata = ws_r.result;

endmodule

// File: tb/tb_vie_wb_stage.sv
// Directed self-checking bench for vie_wb_stage.
module tb_vie_wb_stage;

    logic        clock;
    logic        reset;
    logic [71:0] msbus_i;
    logic        ws_allowin;
    logic [4:0]  rf_raddr1;
    logic [31:0] rf_rdata1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [39:0] wstatus_o;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int checks;
    int failures;

    vie_wb_stage dut (
        .clock             (clock),
        .reset             (reset),
        .msbus_i           (msbus_i),
        .ws_allowin        (ws_allowin),
        .rf_raddr1         (rf_raddr1),
        .rf_rdata1         (rf_rdata1),
        .rf_raddr2         (rf_raddr2),
        .rf_rdata2         (rf_rdata2),
        .hi_o              (hi_o),
        .lo_o              (lo_o),
        .wstatus_o         (wstatus_o),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [6:0] dest, input logic [31:0] pc, input logic [31:0] res);
        msbus_i = {1'b1, dest, pc, res};
    endtask

    task automatic idle();
        msbus_i = {1'b0, 7'd0, 32'd0, 32'd0};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        rf_raddr1 = 5'd0;
        rf_raddr2 = 5'd0;
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (ws_allowin !== 1'b1) begin
            failures++;
            $display("FAIL reset_allowin got=%b want=1", ws_allowin);
        end
        checks++;
        if (wstatus_o[39] !== 1'b0) begin
            failures++;
            $display("FAIL reset_ws_valid got=%b want=0", wstatus_o[39]);
        end
        checks++;
        if (debug_wb_rf_wen !== 4'h0) begin
            failures++;
            $display("FAIL reset_wen got=%h want=0", debug_wb_rf_wen);
        end
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_hilo got=%h/%h want=0/0", hi_o, lo_o);
        end
        $display("reset: allowin=%b ws_valid=%b wen=%h hi=%h lo=%h",
                 ws_allowin, wstatus_o[39], debug_wb_rf_wen, hi_o, lo_o);
    endtask

    task automatic test_gpr_write();
        present(7'd5, 32'hbfc00010, 32'h12345678);
        rf_raddr1 = 5'd5;
        step();
        idle();
        #1;
        checks++;
        if (debug_wb_rf_wen !== 4'hf || debug_wb_rf_wnum !== 5'd5 || debug_wb_pc !== 32'hbfc00010
            || debug_wb_rf_wdata !== 32'h12345678) begin
            failures++;
            $display("FAIL gpr_trace got wen=%h wnum=%0d pc=%h wdata=%h want wen=f wnum=5 pc=bfc00010 wdata=12345678",
                     debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_pc, debug_wb_rf_wdata);
        end
        checks++;
        if (wstatus_o !== {1'b1, 7'd5, 32'h12345678}) begin
            failures++;
            $display("FAIL gpr_wstatus got=%h want=%h", wstatus_o, {1'b1, 7'd5, 32'h12345678});
        end
        checks++;
        if (rf_rdata1 !== 32'h12345678) begin
            failures++;
            $display("FAIL gpr_bypass got=%h want=12345678", rf_rdata1);
        end
        step();
        checks++;
        if (rf_rdata1 !== 32'h12345678) begin
            failures++;
            $display("FAIL gpr_array got=%h want=12345678", rf_rdata1);
        end
        checks++;
        if (debug_wb_rf_wen !== 4'h0 || wstatus_o[39] !== 1'b0) begin
            failures++;
            $display("FAIL gpr_bubble got wen=%h valid=%b want wen=0 valid=0", debug_wb_rf_wen, wstatus_o[39]);
        end
        $display("gpr: r5=%h", rf_rdata1);
    endtask

    task automatic test_hilo();
        present(7'd32, 32'hbfc00020, 32'hdead0001);
        step();
        present(7'd33, 32'hbfc00024, 32'hbeef0002);
        #1;
        checks++;
        if (debug_wb_rf_wen !== 4'h0 || hi_o !== 32'd0) begin
            failures++;
            $display("FAIL hi_in_wb got wen=%h hi=%h want wen=0 hi=0", debug_wb_rf_wen, hi_o);
        end
        step();
        idle();
        #1;
        checks++;
        if (hi_o !== 32'hdead0001 || lo_o !== 32'd0 || debug_wb_rf_wen !== 4'h0) begin
            failures++;
            $display("FAIL hi_commit got hi=%h lo=%h wen=%h want hi=dead0001 lo=0 wen=0", hi_o, lo_o, debug_wb_rf_wen);
        end
        step();
        checks++;
        if (lo_o !== 32'hbeef0002 || hi_o !== 32'hdead0001) begin
            failures++;
            $display("FAIL lo_commit got hi=%h lo=%h want hi=dead0001 lo=beef0002", hi_o, lo_o);
        end
        $display("hilo: hi=%h lo=%h", hi_o, lo_o);
    endtask

    task automatic test_r0();
        present(7'd0, 32'hbfc00030, 32'hffffffff);
        rf_raddr1 = 5'd0;
        step();
        idle();
        #1;
        checks++;
        if (rf_rdata1 !== 32'd0 || debug_wb_rf_wen !== 4'h0 || wstatus_o[39] !== 1'b1) begin
            failures++;
            $display("FAIL r0_in_wb got rdata=%h wen=%h valid=%b want rdata=0 wen=0 valid=1",
                     rf_rdata1, debug_wb_rf_wen, wstatus_o[39]);
        end
        step();
        checks++;
        if (rf_rdata1 !== 32'd0) begin
            failures++;
            $display("FAIL r0_after got=%h want=0", rf_rdata1);
        end
        $display("r0: rdata=%h", rf_rdata1);
    endtask

    task automatic test_back_to_back();
        rf_raddr1 = 5'd7;
        rf_raddr2 = 5'd7;
        present(7'd7, 32'hbfc00040, 32'd11);
        step();
        present(7'd7, 32'hbfc00044, 32'd22);
        #1;
        checks++;
        if (rf_rdata1 !== 32'd11 || rf_rdata2 !== 32'd11) begin
            failures++;
            $display("FAIL b2b_first got=%0d/%0d want=11/11", rf_rdata1, rf_rdata2);
        end
        step();
        idle();
        #1;
        checks++;
        if (rf_rdata1 !== 32'd22 || rf_rdata2 !== 32'd22 || debug_wb_pc !== 32'hbfc00044) begin
            failures++;
            $display("FAIL b2b_second got=%0d/%0d pc=%h want=22/22 pc=bfc00044", rf_rdata1, rf_rdata2, debug_wb_pc);
        end
        step();
        checks++;
        if (rf_rdata1 !== 32'd22 || rf_rdata2 !== 32'd22) begin
            failures++;
            $display("FAIL b2b_after got=%0d/%0d want=22/22", rf_rdata1, rf_rdata2);
        end
        // second port must not follow the first port's address
        rf_raddr2 = 5'd5;
        #1;
        checks++;
        if (rf_rdata2 !== 32'h12345678 || rf_rdata1 !== 32'd22) begin
            failures++;
            $display("FAIL port_independence got=%h/%h want=00000016/12345678", rf_rdata1, rf_rdata2);
        end
        $display("b2b: r7=%0d r5=%h", rf_rdata1, rf_rdata2);
    endtask

    task automatic test_reset_mid();
        rf_raddr1 = 5'd9;
        present(7'd9, 32'hbfc00050, 32'd3);
        step();
        idle();
        step();
        present(7'd9, 32'hbfc00054, 32'd5);
        step();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (rf_rdata1 !== 32'd3) begin
            failures++;
            $display("FAIL reset_mid_r9 got=%0d want=3", rf_rdata1);
        end
        checks++;
        if (wstatus_o[39] !== 1'b0 || debug_wb_rf_wen !== 4'h0) begin
            failures++;
            $display("FAIL reset_mid_state got valid=%b wen=%h want valid=0 wen=0", wstatus_o[39], debug_wb_rf_wen);
        end
        step();
        checks++;
        if (rf_rdata1 !== 32'd3 || debug_wb_rf_wen !== 4'h0) begin
            failures++;
            $display("FAIL reset_mid_after got r9=%0d wen=%h want r9=3 wen=0", rf_rdata1, debug_wb_rf_wen);
        end
        $display("reset_mid: r9=%0d valid=%b", rf_rdata1, wstatus_o[39]);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        msbus_i = '0;
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        test_reset();
        test_gpr_write();
        test_hilo();
        test_r0();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
